// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multicycle MIPS main control FSM with retired-instruction counter
//
// Sequences lw, sw, R-type, beq, bne, addi, ori and j through fetch/decode/
// execute/memory/writeback states and drives the datapath controls.
//
// Ports:
//   clk        in   core clock, rising edge
//   reset      in   asynchronous active-low reset
//   op         in   [5:0] opcode from the instruction register
//   zero       in   ALU zero flag, meaningful in BRANCH
//   pcen       out  PC enable (jump/fetch write, or taken beq/bne)
//   irwrite    out  instruction register write
//   memwrite   out  memory write strobe
//   regwrite   out  register file write
//   iord       out  memory address select (1 = ALUOut)
//   regdst     out  destination select (1 = rd)
//   memtoreg   out  writeback select (1 = data register)
//   alusrca    out  ALU A select (1 = rs)
//   alusrcb    out  [1:0] ALU B select (rt, 4, imm, imm<<2)
//   zeroext    out  immediate zero-extend (ori)
//   pcsrc      out  [1:0] next-PC select (ALUResult, ALUOut, jump target)
//   aluop      out  [1:0] to the ALU decoder
//   instr_done out  pulse in the final state of each instruction
//   illegal_op out  pulse in DECODE for an unsupported opcode
//   instret    out  [INSTRET_W-1:0] retired-instruction count
//   state      out  [3:0] current state, debug

module mips_mc_controller #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic                 zero,
  output logic                 pcen,
  output logic                 irwrite,
  output logic                 memwrite,
  output logic                 regwrite,
  output logic                 iord,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic                 zeroext,
  output logic [1:0]           pcsrc,
  output logic [1:0]           aluop,
  output logic                 instr_done,
  output logic                 illegal_op,
  output logic [INSTRET_W-1:0] instret,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ORIEX   = 4'd12,
    S_ORIWB   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       instr_done;
  } ctrl_t;

  // Moore control word for a given state; anything not listed is 0, which
  // also covers the unused codes 14/15.
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = 2'b01;
      end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR,
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg   = 1'b1;
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.iord       = 1'b1;
        c.memwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      S_ALUWB: begin
        c.regdst     = 1'b1;
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca    = 1'b1;
        c.aluop      = 2'b01;
        c.pcsrc      = 2'b01;
        c.branch     = 1'b1;
        c.instr_done = 1'b1;
      end
      S_ORIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.zeroext = 1'b1;
        c.aluop   = 2'b11;
      end
      S_ADDIWB,
      S_ORIWB: begin
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      S_JUMP: begin
        c.pcsrc      = 2'b10;
        c.pcwrite    = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t                 state_q, state_d;
  ctrl_t                  ctrl_q;
  logic [INSTRET_W-1:0]   instret_q;
  logic                   op_legal;
  logic                   bne;

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ORI, OP_LW, OP_SW: op_legal = 1'b1;
      default:                       op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXECUTE;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_ORI:         state_d = S_ORIEX;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ORIEX:   state_d = S_ORIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Control word is registered from the next state so outputs come straight
  // off flops yet still line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= ctrl_of(S_FETCH);
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
      if (ctrl_q.instr_done) begin
        instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bne = (op == OP_BNE);

  // Strobes are gated by reset so nothing writes while reset is asserted.
  assign pcen       = reset & (ctrl_q.pcwrite | (ctrl_q.branch & (zero ^ bne)));
  assign irwrite    = reset & ctrl_q.irwrite;
  assign memwrite   = reset & ctrl_q.memwrite;
  assign regwrite   = reset & ctrl_q.regwrite;
  assign instr_done = reset & ctrl_q.instr_done;
  assign illegal_op = reset & (state_q == S_DECODE) & ~op_legal;

  assign iord     = ctrl_q.iord;
  assign regdst   = ctrl_q.regdst;
  assign memtoreg = ctrl_q.memtoreg;
  assign alusrca  = ctrl_q.alusrca;
  assign alusrcb  = ctrl_q.alusrcb;
  assign zeroext  = ctrl_q.zeroext;
  assign pcsrc    = ctrl_q.pcsrc;
  assign aluop    = ctrl_q.aluop;
  assign instret  = instret_q;
  assign state    = state_q;

endmodule
